// File: rtl/bit_population_generator.sv
// rtl/bit_population_generator.sv - builds a WIDTH-bit word with a requested number of contiguous ones
module bit_population_generator #(
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [$clog2(WIDTH):0]   cnt_i,
    input  logic [$clog2(WIDTH)-1:0] rot_i,
    input  logic                     data_val_i,
    output logic                     ready_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     data_val_o
);

    localparam int RW = $clog2(WIDTH);
    localparam int CW = RW + 1;
    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [RW-1:0] LAST_PTR = RW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_set;
    logic [RW-1:0]    ptr;
    logic [RW-1:0]    start_ptr;
    logic [CW-1:0]    remaining;
    logic [CW-1:0]    eff_cnt;

    // Requests above WIDTH saturate; out-of-range start positions fold to bit 0.
    always_comb begin
        eff_cnt       = (cnt_i > WIDTH_C) ? WIDTH_C : cnt_i;
        start_ptr     = ({1'b0, rot_i} < WIDTH_C) ? rot_i : '0;
        work_set      = work;
        work_set[ptr] = 1'b1;
    end

    assign ready_o = (state == IDLE);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            work       <= '0;
            ptr        <= '0;
            remaining  <= '0;
            data_o     <= '0;
            data_val_o <= 1'b0;
        end else begin
            data_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_val_i) begin
                        work <= '0;
                        ptr  <= start_ptr;
                        if (eff_cnt == '0) begin
                            data_o     <= '0;
                            data_val_o <= 1'b1;
                        end else begin
                            remaining <= eff_cnt;
                            state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    work      <= work_set;
                    ptr       <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    // Last bit goes straight to the output so the word appears without an extra cycle.
                    if (remaining == CW'(1)) begin
                        data_o     <= work_set;
                        data_val_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_population_generator.md
Name: bit_population_generator

Overview:
Inverse of the bit population counter: accepts a requested population count and a start position, and builds a WIDTH-bit word containing exactly that many ones. The ones are placed contiguously, starting at the start position and wrapping modulo WIDTH. The word is built one bit per clock, so the block is sequential with a ready/valid input handshake. It is used as a stimulus source and loopback partner for the population counter: its output, fed to the counter, must return the requested count.

Parameters:
WIDTH, 32, output word width in bits; must be >= 2.

Ports:
clk_i  input  1  clock; all logic on the rising edge
arst_n_i  input  1  asynchronous active-low reset
cnt_i  input  $clog2(WIDTH)+1  requested number of ones
rot_i  input  $clog2(WIDTH)  bit index of the first one
data_val_i  input  1  request valid; accepted when data_val_i && ready_o at a rising edge
ready_o  output  1  high when a request can be accepted
data_o  output  WIDTH  generated word
data_val_o  output  1  one-cycle pulse, data_o valid

Behaviour:
- Reset: the reset is asynchronous and active-low. While arst_n_i = 0:
  - data_o = 0, data_val_o = 0.
  - FSM = IDLE, so ready_o = 1.
  - Working word, pointer and remaining counter = 0.
- ready_o is combinational: ready_o = (state == IDLE).
- FSM states: IDLE and FILL.
- IDLE, when a request is accepted at edge k:
  - eff_cnt = min(cnt_i, WIDTH); values above WIDTH saturate to WIDTH.
  - ptr = rot_i if rot_i < WIDTH, else 0.
  - Working word cleared to 0.
  - If eff_cnt == 0: data_o <= 0 and data_val_o <= 1 at edge k; the FSM stays in IDLE.
  - If eff_cnt > 0: remaining <= eff_cnt and the FSM goes to FILL.
- FILL, at each edge:
  - work[ptr] set to 1.
  - ptr <= (ptr == WIDTH-1) ? 0 : ptr+1.
  - remaining decremented by 1.
  - On the edge where remaining == 1: data_o <= work with the current bit set, data_val_o <= 1, FSM goes to IDLE.
- Latency: data_val_o is high for exactly the one cycle following edge k + eff_cnt. This covers eff_cnt = 0 (the cycle after edge k).
- Throughput:
  - The next request can be accepted at edge k + eff_cnt + 1.
  - cnt_i = 0 requests can be accepted back-to-back every cycle.
- Inputs are ignored while ready_o = 0, and data_val_i during FILL is not queued.
- cnt_i and rot_i are sampled only at the accept edge; later changes have no effect.
- data_o holds its last value between pulses and changes only on an edge that also asserts data_val_o.
- Invariant: popcount(data_o) == eff_cnt on every data_val_o pulse.
- Wrap-around: the ones occupy indices rot_i .. rot_i+eff_cnt-1, taken mod WIDTH.
- eff_cnt == WIDTH gives an all-ones word for any rot_i.
- Reset during FILL aborts the request immediately: no data_val_o pulse, data_o = 0, ready_o = 1 after release.
- Reset release: the first accept is possible at the first rising edge with arst_n_i = 1.

Test Plan:
- Reset check (WIDTH=8): drive arst_n_i low mid-cycle -> data_o = 0x00, data_val_o = 0, ready_o = 1 immediately, without waiting for a clock edge.
- Basic request: cnt_i=3, rot_i=0, accepted at edge k -> ready_o low for 3 cycles, data_val_o pulses after edge k+3, data_o = 0x07.
- Wrap-around: cnt_i=3, rot_i=6 -> data_o = 0xC1, popcount = 3.
- Saturation and full word: cnt_i=12, rot_i=5 -> data_o = 0xFF after 8 fill cycles.
- Zero count: cnt_i=0 on three consecutive cycles -> three consecutive data_val_o pulses, each with data_o = 0x00, and ready_o stays 1.
- Abort and loopback:
  - Assert reset after 2 of 5 fill edges -> no data_val_o, data_o = 0, ready_o = 1.
  - Random cnt_i/rot_i fed through the population counter -> counter output equals min(cnt_i, WIDTH) on every pulse.
